// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, the IF/MEM requesters and the shared memory port.
// The arbiter uses the slave modport; the requesters and memory together use master.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic        if_valid_o;
    logic [63:0] if_rdata_o;

    logic        mem_req_i;
    logic        mem_we_i;
    logic [63:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [7:0]  mem_wmask_i;
    logic        mem_valid_o;
    logic [63:0] mem_rdata_o;

    logic        err_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [63:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_wmask_o;
    logic        bus_ack_i;
    logic [63:0] bus_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
        input  bus_ack_i, bus_rdata_i,
        output if_valid_o, if_rdata_o, mem_valid_o, mem_rdata_o, err_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
        output bus_ack_i, bus_rdata_i,
        input  if_valid_o, if_rdata_o, mem_valid_o, mem_rdata_o, err_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between instruction fetch and load/store,
// with an access timeout and pipeline hold flags.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave port,
    output logic [2:0]   stall_flag_o
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef enum logic {OWNER_IF, OWNER_MEM} owner_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state, state_next;
    owner_t      owner, last_owner;
    logic [7:0]  count;
    logic [7:0]  count_inc;
    logic        timed_out;
    logic        grant, grant_mem, ack_hit, expire;
    logic [63:0] resp_data;

    logic        bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wmask;
    logic [63:0] if_rdata, mem_rdata;

    assign count_inc = count + 8'd1;
    assign resp_data = (expire || bus_we) ? 64'd0 : port.bus_rdata_i;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // An ack is only honoured in BUS, and it beats the timeout when both land in the same cycle.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_mem  = 1'b0;
        ack_hit    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (port.if_req_i || port.mem_req_i) begin
                    grant      = 1'b1;
                    grant_mem  = port.mem_req_i && (!port.if_req_i || last_owner == OWNER_IF);
                    state_next = BUS;
                end
            end
            BUS: begin
                if (port.bus_ack_i) begin
                    ack_hit    = 1'b1;
                    state_next = RESP;
                end else if (count_inc == LIMIT) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWNER_IF;
            last_owner <= OWNER_IF;
            count      <= 8'd0;
            timed_out  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 64'd0;
            bus_wdata  <= 64'd0;
            bus_wmask  <= 8'd0;
            if_rdata   <= 64'd0;
            mem_rdata  <= 64'd0;
        end else begin
            if (grant) begin
                count     <= 8'd0;
                timed_out <= 1'b0;
                if (grant_mem) begin
                    owner      <= OWNER_MEM;
                    last_owner <= OWNER_MEM;
                    bus_we     <= port.mem_we_i;
                    bus_addr   <= port.mem_addr_i;
                    bus_wdata  <= port.mem_wdata_i;
                    bus_wmask  <= port.mem_wmask_i;
                end else begin
                    owner      <= OWNER_IF;
                    last_owner <= OWNER_IF;
                    bus_we     <= 1'b0;
                    bus_addr   <= port.if_addr_i;
                    bus_wdata  <= 64'd0;
                    bus_wmask  <= 8'd0;
                end
            end
            if (state == BUS && !ack_hit && !expire) count <= count_inc;
            if (expire) timed_out <= 1'b1;
            // Read data lands in the owner's holding register so it stays valid after the pulse.
            if (ack_hit || expire) begin
                if (owner == OWNER_MEM) mem_rdata <= resp_data;
                else                    if_rdata  <= resp_data;
            end
        end
    end

    assign port.bus_req_o   = (state == BUS);
    assign port.bus_we_o    = bus_we;
    assign port.bus_addr_o  = bus_addr;
    assign port.bus_wdata_o = bus_wdata;
    assign port.bus_wmask_o = bus_wmask;

    assign port.if_valid_o  = (state == RESP) && (owner == OWNER_IF);
    assign port.mem_valid_o = (state == RESP) && (owner == OWNER_MEM);
    assign port.err_o       = (state == RESP) && timed_out;
    assign port.if_rdata_o  = if_rdata;
    assign port.mem_rdata_o = mem_rdata;

    assign stall_flag_o = {port.mem_req_i & ~port.mem_valid_o, 1'b0, port.if_req_i & ~port.if_valid_o};

endmodule
